// File: rtl/ofs_fim_pcie_pkg.sv
// ofs_fim_pcie_pkg: shared PCIe FLR function and stream types
package ofs_fim_pcie_pkg;

    localparam int PF_WIDTH = 3;
    localparam int VF_WIDTH = 11;

    typedef struct packed {
        logic                vf_active;
        logic [VF_WIDTH-1:0] vf;
        logic [PF_WIDTH-1:0] pf;
    } t_flr_func;

    typedef struct packed {
        logic      tvalid;
        t_flr_func tdata;
    } t_axis_pcie_flr;

endpackage

// File: rtl/flr_req_fifo.sv
// flr_req_fifo: synchronous FIFO of pending FLR requests with push/pop/full/empty/count
module flr_req_fifo
    import ofs_fim_pcie_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  t_flr_func     push_data,
    input  logic          pop,
    output t_flr_func     pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    t_flr_func     mem_q [DEPTH];
    t_flr_func     mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full     = cnt_q == CW'(DEPTH);
    assign empty    = cnt_q == '0;
    assign count    = cnt_q;
    assign pop_data = mem_q[rd_q];
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;

    // next-state for storage, pointers (wrapping modulo DEPTH) and occupancy
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_ok) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (pop_ok) rd_d = rd_q + AW'(1);
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flr_rsp_handler.sv
// flr_rsp_handler: queues FLR requests, holds function reset, waits for ack, returns completion
module flr_rsp_handler
    import ofs_fim_pcie_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 64,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  t_axis_pcie_flr flr_req_if,
    output t_axis_pcie_flr flr_rsp_if,
    output logic           func_rst_valid,
    output t_flr_func      func_rst_func,
    input  logic           func_rst_ack,
    output logic           busy,
    output logic           overflow_err,
    output logic           timeout_err
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);
    localparam logic [15:0] TMO_INIT  = 16'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, RESP} state_e;

    state_e        state_q, state_d;
    t_flr_func     func_q, func_d;
    logic [15:0]   hold_q, hold_d, tmo_q, tmo_d;
    logic          ovf_q, ovf_d, tmo_err_q, tmo_err_d;
    logic          fifo_pop, fifo_full, fifo_empty;
    t_flr_func     fifo_data;
    logic [CW-1:0] fifo_count;

    flr_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (flr_req_if.tvalid),
        .push_data (flr_req_if.tdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // sequencing: pop request, hold reset HOLD_CYCLES, wait for ack or timeout, respond
    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    func_d   = fifo_data;
                    hold_d   = HOLD_INIT;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (hold_q <= 16'd1) begin
                    hold_d  = '0;
                    tmo_d   = TMO_INIT;
                    state_d = WAIT_ACK;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            WAIT_ACK: begin
                if (func_rst_ack) begin
                    state_d = RESP;
                end else if (tmo_q <= 16'd1) begin
                    tmo_d     = '0;
                    tmo_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_q | (flr_req_if.tvalid & fifo_full & ~fifo_pop);
    end

    // FSM, function register, counters and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            func_q    <= '0;
            hold_q    <= '0;
            tmo_q     <= '0;
            ovf_q     <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            ovf_q     <= ovf_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign func_rst_valid = state_q == ASSERT;
    assign func_rst_func  = func_q;
    assign flr_rsp_if     = '{tvalid: state_q == RESP, tdata: func_q};
    assign busy           = state_q != IDLE || fifo_count != '0;
    assign overflow_err   = ovf_q;
    assign timeout_err    = tmo_err_q;

endmodule

// File: tb/tb_flr_rsp_handler.sv
// tb_flr_rsp_handler: randomized and directed checks against a job-schedule model
module tb_flr_rsp_handler;
    import ofs_fim_pcie_pkg::*;

    localparam int D = 4, H = 64, T = 16, MAXC = 8192, MAXJ = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    t_axis_pcie_flr req_if, rsp_if;
    logic frv, ack_in, busy, ovf, tmo;
    t_flr_func frf;

    flr_rsp_handler #(.FIFO_DEPTH(D), .HOLD_CYCLES(H), .ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .flr_req_if(req_if), .flr_rsp_if(rsp_if),
        .func_rst_valid(frv), .func_rst_func(frf), .func_rst_ack(ack_in),
        .busy(busy), .overflow_err(ovf), .timeout_err(tmo)
    );

    int total = 0, bad = 0;
    int n_jobs, ncyc;
    int ja [MAXJ];
    int jd [MAXJ];
    bit je [MAXJ];
    t_flr_func jf [MAXJ];
    bit rq_v [MAXC];
    t_flr_func rq_f [MAXC];
    bit ack_s [MAXC];
    bit ev [MAXC];
    bit erv [MAXC];
    bit eb [MAXC];
    t_flr_func ef [MAXC];
    t_flr_func erf [MAXC];
    bit exp_ovf, exp_tmo;
    logic ov [MAXC];
    logic orv [MAXC];
    logic ob [MAXC];
    t_flr_func of [MAXC];
    t_flr_func orf [MAXC];

    // Job-level model: each accepted job starts one cycle after arrival or after the
    // previous response, whichever is later; drops happen when D jobs wait and none leaves.
    task automatic build();
        int acc_a [MAXJ];
        int acc_p [MAXJ];
        int nacc = 0, last_r = -1, last_a = 0, occ, p, w, r;
        bit pop;
        for (int c = 0; c < MAXC; c++) begin
            rq_v[c] = 0; rq_f[c] = '0; ack_s[c] = 0; ev[c] = 0; erv[c] = 0; eb[c] = 0;
            ef[c] = '0; erf[c] = '0;
        end
        exp_ovf = 0; exp_tmo = 0;
        for (int i = 0; i < n_jobs; i++) begin
            rq_v[ja[i]] = 1; rq_f[ja[i]] = jf[i]; last_a = ja[i];
            occ = 0; pop = 0;
            for (int j = 0; j < nacc; j++) begin
                if (acc_a[j] < ja[i] && ja[i] <= acc_p[j]) occ++;
                if (acc_p[j] == ja[i]) pop = 1;
            end
            if (occ == D && !pop) begin
                exp_ovf = 1;
                continue;
            end
            p = (ja[i] + 1 > last_r + 1) ? ja[i] + 1 : last_r + 1;
            w = p + H + 1;
            if (jd[i] < T) begin
                ack_s[w + jd[i]] = 1; r = w + jd[i] + 1;
            end else begin
                r = w + T; exp_tmo = 1;
            end
            if (je[i]) ack_s[p + 1 + int'($urandom_range(H - 1, 0))] = 1;
            for (int c = p + 1; c <= p + H; c++) begin ev[c] = 1; ef[c] = jf[i]; end
            erv[r] = 1; erf[r] = jf[i];
            for (int c = ja[i] + 1; c <= r; c++) eb[c] = 1;
            acc_a[nacc] = ja[i]; acc_p[nacc] = p; nacc++; last_r = r;
        end
        ncyc = ((last_r > last_a) ? last_r : last_a) + 8;
    endtask

    task automatic do_reset();
        rst_n = 0; req_if = '0; ack_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
    endtask

    task automatic play();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            req_if.tvalid = rq_v[c]; req_if.tdata = rq_f[c]; ack_in = ack_s[c];
            ov[c] = frv; of[c] = frf; orv[c] = rsp_if.tvalid; orf[c] = rsp_if.tdata; ob[c] = busy;
        end
        @(posedge clk); #1;
        req_if = '0; ack_in = 0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (frv !== 0 || frf !== '0 || rsp_if !== '0 || busy !== 0 || ovf !== 0 || tmo !== 0) begin
            bad++;
            $display("FAIL reset_outputs: got frv=%b frf=%h rsp=%h busy=%b ovf=%b tmo=%b want all 0",
                     frv, frf, rsp_if, busy, ovf, tmo);
        end
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (frv !== 0 || rsp_if.tvalid !== 0 || busy !== 0) begin
            bad++;
            $display("FAIL reset_idle: got frv=%b rsp_v=%b busy=%b want 0 0 0", frv, rsp_if.tvalid, busy);
        end
    endtask

    task automatic test_single();
        n_jobs = 1; ja[0] = 2; jf[0] = '0; jd[0] = 3; je[0] = 0;
        do_reset(); build(); play();
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (ov[c] !== ev[c] || (ev[c] && of[c] !== ef[c]) || orv[c] !== erv[c] ||
                (erv[c] && orf[c] !== erf[c]) || ob[c] !== eb[c]) begin
                bad++;
                $display("FAIL single c=%0d: got v=%b f=%h rv=%b rf=%h busy=%b want v=%b f=%h rv=%b rf=%h busy=%b",
                         c, ov[c], of[c], orv[c], orf[c], ob[c], ev[c], ef[c], erv[c], erf[c], eb[c]);
            end
        end
        total++;
        if (ovf !== 0 || tmo !== 0) begin
            bad++; $display("FAIL single_err: got ovf=%b tmo=%b want 0 0", ovf, tmo);
        end
    endtask

    task automatic test_back_to_back();
        n_jobs = 2; ja[0] = 2; ja[1] = 3; jd[0] = 0; jd[1] = 5; je[0] = 0; je[1] = 0;
        jf[0] = '{vf_active: 1'b1, vf: 11'd5, pf: 3'd1};
        jf[1] = '{vf_active: 1'b1, vf: 11'd2, pf: 3'd0};
        do_reset(); build(); play();
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (ov[c] !== ev[c] || (ev[c] && of[c] !== ef[c]) || orv[c] !== erv[c] ||
                (erv[c] && orf[c] !== erf[c]) || ob[c] !== eb[c]) begin
                bad++;
                $display("FAIL back_to_back c=%0d: got v=%b f=%h rv=%b rf=%h busy=%b want v=%b f=%h rv=%b rf=%h busy=%b",
                         c, ov[c], of[c], orv[c], orf[c], ob[c], ev[c], ef[c], erv[c], erf[c], eb[c]);
            end
        end
        total++;
        if (ovf !== 0 || tmo !== 0) begin
            bad++; $display("FAIL back_to_back_err: got ovf=%b tmo=%b want 0 0", ovf, tmo);
        end
    endtask

    task automatic test_overflow();
        int nrsp = 0;
        n_jobs = 6;
        for (int i = 0; i < 6; i++) begin
            ja[i] = (i == 0) ? 2 : 3 + i; jd[i] = 1; je[i] = 0;
            jf[i] = '{vf_active: 1'b0, vf: 11'(i), pf: 3'(i)};
        end
        do_reset(); build(); play();
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (orv[c] === 1'b1) nrsp++;
            if (ov[c] !== ev[c] || (ev[c] && of[c] !== ef[c]) || orv[c] !== erv[c] ||
                (erv[c] && orf[c] !== erf[c]) || ob[c] !== eb[c]) begin
                bad++;
                $display("FAIL overflow c=%0d: got v=%b f=%h rv=%b rf=%h busy=%b want v=%b f=%h rv=%b rf=%h busy=%b",
                         c, ov[c], of[c], orv[c], orf[c], ob[c], ev[c], ef[c], erv[c], erf[c], eb[c]);
            end
        end
        total++;
        if (nrsp != 5 || ovf !== 1 || tmo !== 0) begin
            bad++; $display("FAIL overflow_sum: got rsp=%0d ovf=%b tmo=%b want 5 1 0", nrsp, ovf, tmo);
        end
    endtask

    task automatic test_timeout();
        n_jobs = 2; ja[0] = 2; ja[1] = 3; jd[0] = T; jd[1] = T - 1; je[0] = 1; je[1] = 0;
        jf[0] = '{vf_active: 1'b0, vf: 11'd0, pf: 3'd3};
        jf[1] = '{vf_active: 1'b1, vf: 11'd7, pf: 3'd2};
        do_reset(); build(); play();
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (ov[c] !== ev[c] || (ev[c] && of[c] !== ef[c]) || orv[c] !== erv[c] ||
                (erv[c] && orf[c] !== erf[c]) || ob[c] !== eb[c]) begin
                bad++;
                $display("FAIL timeout c=%0d: got v=%b f=%h rv=%b rf=%h busy=%b want v=%b f=%h rv=%b rf=%h busy=%b",
                         c, ov[c], of[c], orv[c], orf[c], ob[c], ev[c], ef[c], erv[c], erf[c], eb[c]);
            end
        end
        total++;
        if (ovf !== 0 || tmo !== 1) begin
            bad++; $display("FAIL timeout_err: got ovf=%b tmo=%b want 0 1", ovf, tmo);
        end
    endtask

    task automatic test_random();
        int a = 1;
        logic [31:0] rv;
        n_jobs = 12 + int'($urandom_range(8, 0));
        for (int i = 0; i < n_jobs; i++) begin
            a += ($urandom_range(2, 0) == 0) ? int'($urandom_range(200, 1)) : int'($urandom_range(2, 1));
            ja[i] = a;
            rv = $urandom;
            jf[i] = rv[$bits(t_flr_func)-1:0];
            jd[i] = int'($urandom_range(20, 0));
            je[i] = $urandom_range(3, 0) == 0;
        end
        do_reset(); build(); play();
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (ov[c] !== ev[c] || (ev[c] && of[c] !== ef[c]) || orv[c] !== erv[c] ||
                (erv[c] && orf[c] !== erf[c]) || ob[c] !== eb[c]) begin
                bad++;
                $display("FAIL random c=%0d: got v=%b f=%h rv=%b rf=%h busy=%b want v=%b f=%h rv=%b rf=%h busy=%b",
                         c, ov[c], of[c], orv[c], orf[c], ob[c], ev[c], ef[c], erv[c], erf[c], eb[c]);
            end
        end
        total++;
        if (ovf !== exp_ovf || tmo !== exp_tmo) begin
            bad++; $display("FAIL random_err: got ovf=%b tmo=%b want %b %b", ovf, tmo, exp_ovf, exp_tmo);
        end
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        n_jobs = 3;
        for (int i = 0; i < 3; i++) begin
            ja[i] = i; jd[i] = 0; je[i] = 0; jf[i] = '{vf_active: 1'b1, vf: 11'(i + 1), pf: 3'd4};
        end
        do_reset(); build();
        ncyc = 6;
        play();
        total++;
        if (frv !== 1 || busy !== 1) begin
            bad++; $display("FAIL mid_reset_pre: got frv=%b busy=%b want 1 1", frv, busy);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (frv !== 0 || frf !== '0 || rsp_if !== '0 || busy !== 0 || ovf !== 0 || tmo !== 0) begin
            bad++;
            $display("FAIL mid_reset_async: got frv=%b frf=%h rsp=%h busy=%b ovf=%b tmo=%b want all 0",
                     frv, frf, rsp_if, busy, ovf, tmo);
        end
        @(negedge clk) rst_n = 1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (frv !== 0 || rsp_if.tvalid !== 0 || busy !== 0) seen = 1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL mid_reset_after: got activity after release want none");
        end
    endtask

    initial begin
        req_if = '0; ack_in = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_random();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flr_rsp_handler.md
FLR_RSP_HANDLER -- requirements
Module: flr_rsp_handler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of pending FLR requests queued; power of two, at least 2.
REQ-002 Parameter HOLD_CYCLES, default 64: number of cycles the function reset is held asserted; range 1..65535.
REQ-003 Parameter ACK_TIMEOUT, default 1024: maximum cycles to wait for func_rst_ack; range 1..65535.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: sole clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port flr_req_if, input, t_axis_pcie_flr: FLR request, one-cycle tvalid; tdata carries pf, vf, vf_active.
REQ-008 Port flr_rsp_if, output, t_axis_pcie_flr: FLR completion, one-cycle tvalid; tdata echoes the request.
REQ-009 Port func_rst_valid, input-to-fabric direction output, 1: function reset asserted to the target function.
REQ-010 Port func_rst_func, output, t_flr_func: pf/vf/vf_active of the function being reset.
REQ-011 Port func_rst_ack, input, 1: target function reports reset drained; level or pulse.
REQ-012 Port busy, output, 1: FSM not in IDLE, or FIFO not empty.
REQ-013 Port overflow_err, output, 1: sticky; a request was dropped because the FIFO was full.
REQ-014 Port timeout_err, output, 1: sticky; an ack timeout occurred.

Function
REQ-015 On a cycle with flr_req_if.tvalid=1, tdata is pushed into the FIFO; the input has no backpressure.
REQ-016 A push to a full FIFO in a cycle without a pop is dropped, and overflow_err is set to 1.
REQ-017 A push to a full FIFO in the same cycle as a pop is accepted.
REQ-018 The FSM states are IDLE, ASSERT, WAIT_ACK and RESP.
REQ-019 IDLE with FIFO non-empty: pop the head into the function register, load hold counter = HOLD_CYCLES, and go to ASSERT next cycle.
REQ-020 ASSERT: func_rst_valid=1 and func_rst_func = the registered function; the counter decrements each cycle.
REQ-021 ASSERT leaves for WAIT_ACK after exactly HOLD_CYCLES cycles in ASSERT.
REQ-022 On entry to WAIT_ACK, func_rst_valid=0 and the timeout counter is loaded with ACK_TIMEOUT.
REQ-023 func_rst_ack is ignored outside WAIT_ACK.
REQ-024 WAIT_ACK with func_rst_ack=1: go to RESP next cycle.
REQ-025 WAIT_ACK when the timeout counter reaches 0 without ack: set timeout_err=1 and go to RESP.
REQ-026 RESP: flr_rsp_if.tvalid=1 for exactly one cycle, with tdata = the registered request.
REQ-027 RESP is followed by IDLE.
REQ-028 IDLE-to-ASSERT occurs at the earliest one cycle after RESP, so consecutive requests are separated by at least one IDLE cycle.
REQ-029 Request-to-response latency with an empty FIFO and an immediate ack is 1 (push) + 1 (IDLE pop) + HOLD_CYCLES + 1 (WAIT_ACK) + 1 (RESP) cycles.
REQ-030 Requests are served strictly in FIFO order.
REQ-031 Duplicate requests for the same function are not merged.
REQ-032 The FIFO pointers wrap modulo FIFO_DEPTH.
REQ-033 The FIFO count width is $clog2(FIFO_DEPTH)+1.
REQ-034 The hold and timeout counters are 16 bits.

Reset
REQ-035 rst_n=0 asynchronously clears all state: FSM=IDLE, FIFO empty, both counters 0, and the function register 0.
REQ-036 During reset, all outputs are 0: flr_rsp_if.tvalid, flr_rsp_if.tdata, func_rst_valid, func_rst_func, busy, overflow_err, timeout_err.
REQ-037 Reset mid-operation discards the in-flight and queued requests with no response.
REQ-038 The sticky error bits clear only on reset.

Structure
REQ-039 t_axis_pcie_flr and t_flr_func are reused from ofs_fim_pcie_pkg; no new types are defined.
REQ-040 State encoding, the FIFO depth parameter and the counter widths are local to the module.
REQ-041 One sub-module, flr_req_fifo (a synchronous FIFO with push/pop/full/empty/count), is instantiated.

Verification
REQ-042 Single PF0 request, HOLD_CYCLES=64, ack 3 cycles after func_rst_valid falls -> func_rst_valid high for exactly 64 cycles with func_rst_func.pf=0, then one flr_rsp tvalid with tdata=request.
REQ-043 Requests for VF 5 of PF1 and then VF 2 of PF0 on back-to-back cycles -> two resets in order, responses in the same order, no overflow_err.
REQ-044 Six back-to-back requests with FIFO_DEPTH=4 while the first request is in ASSERT -> exactly one request dropped (the sixth), overflow_err=1, and five responses.
REQ-045 No ack, ACK_TIMEOUT=16 -> flr_rsp tvalid 16 cycles after entering WAIT_ACK and timeout_err=1.
REQ-046 Ack pulsed during ASSERT only -> the ack is ignored; timeout path is taken.
REQ-047 rst_n dropped while in ASSERT with 2 requests queued -> func_rst_valid=0 immediately, no response after release, and busy=0.
